// File: rtl/i2d_wb_pkg.sv
// Shared Wishbone bus widths and types, plus the byte-lane merge used by
// every slave that takes partial-word writes.
package i2d_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef logic [WB_ADR_W-1:0] wb_adr_t;
    typedef logic [WB_DAT_W-1:0] wb_dat_t;
    typedef logic [WB_SEL_W-1:0] wb_sel_t;

    function automatic wb_dat_t wb_merge(input wb_dat_t old_word,
                                         input wb_dat_t new_word,
                                         input wb_sel_t sel);
        wb_dat_t merged;
        merged = old_word;
        for (int i = 0; i < WB_SEL_W; i++) begin
            if (sel[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bundle; pl_slave is the responder view, pl_master the
// requester view.
interface wishbone;
    import i2d_wb_pkg::*;

    logic    cyc;
    logic    stb;
    logic    we;
    wb_adr_t adr;
    wb_sel_t sel;
    wb_dat_t dat_si;
    wb_dat_t dat_so;
    logic    ack;
    logic    stall;

    modport pl_slave  (input cyc, stb, we, adr, sel, dat_si,
                       output dat_so, ack, stall);
    modport pl_master (output cyc, stb, we, adr, sel, dat_si,
                       input dat_so, ack, stall);
endinterface

// File: rtl/wb_resp_pipe.sv
// Fixed-latency response pipe: LATENCY stages of {valid,data}; flush drops
// every in-flight response at once.
module wb_resp_pipe
    import i2d_wb_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_dat_t data,
    input  logic    flush,
    output logic    ack,
    output wb_dat_t dat_so
);

    logic [LATENCY-1:0] valid;
    wb_dat_t            stage [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            valid <= '0;
        end else begin
            valid[0] <= push;
            for (int i = 1; i < LATENCY; i++) begin
                valid[i] <= valid[i-1];
            end
        end
    end

    // Data needs no reset: it is only ever observed through its valid bit.
    always_ff @(posedge clk) begin
        stage[0] <= data;
        for (int i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign ack    = valid[LATENCY-1];
    assign dat_so = valid[LATENCY-1] ? stage[LATENCY-1] : '0;

endmodule

// File: rtl/wb_pl_mem_slave.sv
// Pipelined Wishbone word memory: fixed read latency, byte-lane writes,
// in-order acks and optional periodic stall injection.
module wb_pl_mem_slave
    import i2d_wb_pkg::*;
#(
    parameter int    DEPTH       = 1024,
    parameter int    LATENCY     = 1,
    parameter int    STALL_EVERY = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic      clk,
    input  logic      rst,
    wishbone.pl_slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((STALL_EVERY > 0) ? STALL_EVERY - 1 : 0);

    wb_dat_t          mem [DEPTH];
    logic [AW-1:0]    idx;
    logic             acc;
    logic             stall_q;
    logic [CNT_W-1:0] cnt;
    logic             pipe_ack;
    wb_dat_t          push_data;
    wb_dat_t          pipe_dat;
    logic             unused_adr_bits;

    // Upper address bits alias the array; the byte offset is meaningless for word access.
    assign idx             = bus.adr[AW+1:2];
    assign unused_adr_bits = ^{bus.adr[WB_ADR_W-1:AW+2], bus.adr[1:0]};

    assign acc       = rst && bus.cyc && bus.stb && !stall_q;
    assign push_data = bus.we ? '0 : mem[idx];

    always_ff @(posedge clk) begin
        if (acc && bus.we) begin
            mem[idx] <= wb_merge(mem[idx], bus.dat_si, bus.sel);
        end
    end

    // Stall for one cycle after every STALL_EVERY-th accepted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            stall_q <= 1'b0;
        end else if (acc && (STALL_EVERY > 0) && (cnt == CNT_LAST)) begin
            cnt     <= '0;
            stall_q <= 1'b1;
        end else begin
            if (acc && (STALL_EVERY > 0)) begin
                cnt <= cnt + 1'b1;
            end
            stall_q <= 1'b0;
        end
    end

    wb_resp_pipe #(
        .LATENCY(LATENCY)
    ) u_resp_pipe (
        .clk   (clk),
        .rst   (rst),
        .push  (acc),
        .data  (push_data),
        .flush (!bus.cyc),
        .ack   (pipe_ack),
        .dat_so(pipe_dat)
    );

    // Dropping cyc silences the bus in the same cycle, not just from the next one.
    assign bus.ack    = pipe_ack && bus.cyc;
    assign bus.dat_so = bus.cyc ? pipe_dat : '0;
    assign bus.stall  = stall_q && bus.cyc;

endmodule
